acc_datapath: RTL

//  Datapath responder for the accumulator-CPU control FSM: executes C-strobes on PC, IR, MDR, ACC and a
//  16-word program/data RAM, and returns the one-hot opcode decode lines (INCA..JMP) the FSM branches on.

---
 rtl/acc_datapath.sv | 100 ++++++++++
 1 files changed

// File: rtl/acc_datapath.sv
// acc_datapath: register/RAM datapath executing control strobes for the accumulator CPU
module acc_datapath #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int OP_INCA = 1,
    parameter int OP_CLRA = 2,
    parameter int OP_LDA  = 3,
    parameter int OP_STA  = 4,
    parameter int OP_ADD  = 5,
    parameter int OP_JMP  = 6
) (
    input  logic              clk,
    input  logic              CLR,
    input  logic              C0,
    input  logic              C1,
    input  logic              C2,
    input  logic              C3,
    input  logic              C4,
    input  logic              C5,
    input  logic              C42,
    input  logic              C6,
    input  logic              C7,
    input  logic              C8,
    input  logic              C9,
    input  logic              C10,
    input  logic              C11,
    output logic              INCA,
    output logic              CLRA,
    output logic              LDA,
    output logic              STA,
    output logic              ADD,
    output logic              JMP,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);
    localparam int OP_W = DATA_W - ADDR_W;

    logic [ADDR_W-1:0] pc_q, pc_d, addr;
    logic [DATA_W-1:0] ir_q, ir_d, mdr_q, mdr_d, mem_q, mem_d, acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [DATA_W:0]   sum;
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] ram_q [2**ADDR_W];
    logic              unused_c6;

    assign unused_c6 = C6;
    assign addr      = C3 ? ir_q[ADDR_W-1:0] : pc_q;
    assign opcode    = ir_q[DATA_W-1:ADDR_W];
    assign INCA      = opcode == OP_W'(OP_INCA);
    assign CLRA      = opcode == OP_W'(OP_CLRA);
    assign LDA       = opcode == OP_W'(OP_LDA);
    assign STA       = opcode == OP_W'(OP_STA);
    assign ADD       = opcode == OP_W'(OP_ADD);
    assign JMP       = opcode == OP_W'(OP_JMP);
    assign pc        = pc_q;
    assign acc       = acc_q;
    assign carry     = carry_q;

    // Next-state selection; every register is steered independently so strobes can combine freely
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, mdr_q};
        pc_d    = C0 ? '0 : C1 ? ir_q[ADDR_W-1:0] : C2 ? pc_q + ADDR_W'(1) : pc_q;
        acc_d   = C8 ? '0 : C9 ? acc_q + DATA_W'(1) : !C11 ? (C10 ? sum[DATA_W-1:0] : mdr_q) : acc_q;
        carry_d = C8 ? 1'b0 : (!C9 && !C11 && C10) ? sum[DATA_W] : carry_q;
        mdr_d   = C42 ? mem_q : mdr_q;
        ir_d    = C7 ? mdr_q : ir_q;
        mem_d   = (C4 && !C5) ? ram_q[addr] : mem_q;
    end

    // Architectural registers, cleared immediately by CLR
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            pc_q    <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            mem_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            mem_q   <= mem_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    // Program RAM survives CLR; the loader port overrides a CPU store in the same cycle
    always_ff @(posedge clk) begin
        if (prog_we)
            ram_q[prog_addr] <= prog_data;
        else if (C4 && C5)
            ram_q[addr] <= acc_q;
    end
endmodule
